// File: rtl/xvec_mul_div_lanes_pkg.sv
// Shared op/state encodings for the xvec multi-lane multiply/divide unit.
// The divide datapath is built only when XVEC_MD_DIV_EN is defined; it is left out by default.
package xvec_mul_div_lanes_pkg;

   typedef enum logic [1:0] {
      OP_MUL  = 2'd0,
      OP_MULH = 2'd1,
      OP_DIV  = 2'd2,
      OP_REM  = 2'd3
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_SETUP   = 2'd2,
      ST_DONE    = 2'd3
   } md_state_e;

   function automatic logic is_div_op(input md_op_e op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/xvec_mul_div_lanes_lane.sv
// One lane of the radix-2 shift/add multiplier and restoring divider, plus the final sign/half select.
// The compare/subtract step exists only when XVEC_MD_DIV_EN is defined.
module xvec_mul_div_lanes_lane
   import xvec_mul_div_lanes_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_accept,
   input  md_op_e           i_req_op,
   input  logic             i_req_in_1_signed,
   input  logic             i_req_in_2_signed,
   input  logic             i_req_mask,
   input  logic [XLEN-1:0]  i_req_in_1,
   input  logic [XLEN-1:0]  i_req_in_2,
   input  md_op_e           i_op,
   input  logic             i_mask,
   input  logic [CNT_W-1:0] i_counter,
   input  md_state_e        i_state,
   output logic [XLEN-1:0]  o_result
);

   localparam int IDX_W = $clog2(2 * XLEN);

   logic [2*XLEN-1:0] r_a;
   logic [2*XLEN-1:0] r_b;
   logic [2*XLEN-1:0] r_result;
   logic              r_negate;

   logic              w_neg_1;
   logic              w_neg_2;
   logic [XLEN-1:0]   w_abs_1;
   logic [XLEN-1:0]   w_abs_2;
   logic              w_negate;
   logic [2*XLEN-1:0] w_sel;
   logic [2*XLEN-1:0] w_signed;
   logic [2*XLEN-1:0] w_setup;
   logic [IDX_W-1:0]  w_idx;

   assign w_neg_1 = i_req_in_1_signed & i_req_in_1[XLEN-1];
   assign w_neg_2 = i_req_in_2_signed & i_req_in_2[XLEN-1];
   assign w_abs_1 = w_neg_1 ? -i_req_in_1 : i_req_in_1;
   assign w_abs_2 = w_neg_2 ? -i_req_in_2 : i_req_in_2;
   assign w_idx   = IDX_W'(i_counter);

   // A zero divisor clears the DIV negate so the all-ones quotient comes out unchanged.
   // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
   always_comb begin
      w_negate = 1'b0;
      case (i_req_op)
         OP_MUL, OP_MULH: w_negate = w_neg_1 ^ w_neg_2;
         OP_DIV:          w_negate = (w_neg_1 ^ w_neg_2) & (|i_req_in_2);
         OP_REM:          w_negate = w_neg_1;
         default:         w_negate = 1'b0;
      endcase
   end

   // Masked lanes keep the raw operand in r_a and hand it back in SETUP.
   always_comb begin
      w_sel    = (i_op == OP_REM) ? r_a : r_result;
      w_signed = r_negate ? -w_sel : w_sel;
      if (!i_mask) begin
         w_setup = {{XLEN{1'b0}}, r_a[XLEN-1:0]};
      end else if (i_op == OP_MULH) begin
         w_setup = {{XLEN{1'b0}}, w_signed[2*XLEN-1:XLEN]};
      end else begin
         w_setup = {{XLEN{1'b0}}, w_signed[XLEN-1:0]};
      end
`ifndef XVEC_MD_DIV_EN
      if (is_div_op(i_op)) begin
         w_setup = '0;
      end
`endif
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_negate <= 1'b0;
      end else if (i_accept) begin
         r_a      <= {{XLEN{1'b0}}, (i_req_mask ? w_abs_1 : i_req_in_1)};
         r_b      <= {w_abs_2, {XLEN{1'b0}}} >> 1;
         r_result <= '0;
         r_negate <= i_req_mask & w_negate;
      end else if (i_state == ST_COMPUTE && i_mask) begin
         if (is_div_op(i_op)) begin
`ifdef XVEC_MD_DIV_EN
            if (r_a >= r_b) begin
               r_a             <= r_a - r_b;
               r_result[w_idx] <= 1'b1;
            end
`endif
         end else if (r_a[w_idx]) begin
            r_result <= r_result + r_b;
         end
         r_b <= r_b >> 1;
      end else if (i_state == ST_SETUP) begin
         r_result <= w_setup;
      end
   end

   assign o_result = r_result[XLEN-1:0];

endmodule

// File: rtl/xvec_mul_div_lanes.sv
// Multi-lane iterative MUL/MULH/DIV/REM unit: FSM, shared counter, latched op/mask and handshakes.
// Define XVEC_MD_DIV_EN to build the divide datapath; otherwise DIV/REM return 0 with resp_illegal.
module xvec_mul_div_lanes
   import xvec_mul_div_lanes_pkg::*;
#(
   parameter int LANES = 2,
   parameter int XLEN  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_op,
   input  logic                  req_in_1_signed,
   input  logic                  req_in_2_signed,
   input  logic [LANES-1:0]      req_mask,
   input  logic [LANES*XLEN-1:0] req_in_1,
   input  logic [LANES*XLEN-1:0] req_in_2,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [LANES*XLEN-1:0] resp_result,
   output logic                  resp_illegal
);

   localparam int CNT_W = $clog2(XLEN);

   md_state_e        r_state;
   md_state_e        w_state_next;
   logic [CNT_W-1:0] r_counter;
   md_op_e           r_op;
   logic [LANES-1:0] r_mask;
   logic             r_illegal;
   logic             w_accept;

   assign w_accept     = req_valid & (r_state == ST_IDLE);
   assign req_ready    = (r_state == ST_IDLE);
   assign resp_valid   = (r_state == ST_DONE);
   assign resp_illegal = r_illegal;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_accept)           w_state_next = ST_COMPUTE;
         ST_COMPUTE: if (r_counter == '0)    w_state_next = ST_SETUP;
         ST_SETUP:                           w_state_next = ST_DONE;
         ST_DONE:    if (resp_ready)         w_state_next = ST_IDLE;
         default:                            w_state_next = ST_IDLE;
      endcase
   end

   // The counter wraps after its last COMPUTE step; the FSM has already left COMPUTE by then.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_counter <= '0;
         r_op      <= OP_MUL;
         r_mask    <= '0;
         r_illegal <= 1'b0;
      end else if (w_accept) begin
         r_counter <= CNT_W'(XLEN - 1);
         r_op      <= md_op_e'(req_op);
         r_mask    <= req_mask;
`ifdef XVEC_MD_DIV_EN
         r_illegal <= 1'b0;
`else
         r_illegal <= is_div_op(md_op_e'(req_op));
`endif
      end else if (r_state == ST_COMPUTE) begin
         r_counter <= r_counter - 1'b1;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      xvec_mul_div_lanes_lane #(
         .XLEN  (XLEN),
         .CNT_W (CNT_W)
      ) u_lane (
         .clk               (clk),
         .reset             (reset),
         .i_accept          (w_accept),
         .i_req_op          (md_op_e'(req_op)),
         .i_req_in_1_signed (req_in_1_signed),
         .i_req_in_2_signed (req_in_2_signed),
         .i_req_mask        (req_mask[g]),
         .i_req_in_1        (req_in_1[g*XLEN +: XLEN]),
         .i_req_in_2        (req_in_2[g*XLEN +: XLEN]),
         .i_op              (r_op),
         .i_mask            (r_mask[g]),
         .i_counter         (r_counter),
         .i_state           (r_state),
         .o_result          (resp_result[g*XLEN +: XLEN])
      );
   end

endmodule

// File: tb/tb_xvec_mul_div_lanes.sv
// Self-checking bench for xvec_mul_div_lanes: directed corners plus randomized ops against a 64-bit arithmetic model.
// Expected DIV/REM values follow XVEC_MD_DIV_EN (results when defined, zero plus resp_illegal otherwise).
module tb_xvec_mul_div_lanes;

   localparam int LANES = 2;
   localparam int XLEN  = 32;
   localparam int VW    = LANES * XLEN;

   logic            clk = 1'b0;
   logic            reset;
   logic            req_valid;
   logic            req_ready;
   logic [1:0]      req_op;
   logic            req_in_1_signed;
   logic            req_in_2_signed;
   logic [LANES-1:0] req_mask;
   logic [VW-1:0]   req_in_1;
   logic [VW-1:0]   req_in_2;
   logic            resp_valid;
   logic            resp_ready;
   logic [VW-1:0]   resp_result;
   logic            resp_illegal;

   int              n_checks = 0;
   int              n_errors = 0;
   logic [VW-1:0]   got_result;

   xvec_mul_div_lanes #(.LANES(LANES), .XLEN(XLEN)) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_op          (req_op),
      .req_in_1_signed (req_in_1_signed),
      .req_in_2_signed (req_in_2_signed),
      .req_mask        (req_mask),
      .req_in_1        (req_in_1),
      .req_in_2        (req_in_2),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .resp_result     (resp_result),
      .resp_illegal    (resp_illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit div_enabled();
`ifdef XVEC_MD_DIV_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // Reference: widen to 64-bit integers and use native * / % (C-style truncating division).
   function automatic logic [XLEN-1:0] ref_lane(input logic [1:0] op, input logic s1, input logic s2,
                                                 input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
      longint sx, sy, p, q, r;
      sx = s1 ? longint'($signed(x)) : longint'(x);
      sy = s2 ? longint'($signed(y)) : longint'(y);
      case (op)
         2'd0: begin p = sx * sy; return p[31:0]; end
         2'd1: begin p = sx * sy; return p[63:32]; end
         2'd2: begin
            if (y == '0) return '1;
            q = sx / sy;
            return q[31:0];
         end
         default: begin
            if (y == '0) return x;
            r = sx % sy;
            return r[31:0];
         end
      endcase
   endfunction

   function automatic logic [VW-1:0] ref_vec(input logic [1:0] op, input logic s1, input logic s2,
                                             input logic [LANES-1:0] mask,
                                             input logic [VW-1:0] a, input logic [VW-1:0] b);
      logic [VW-1:0] v;
      v = '0;
      if (op >= 2'd2 && !div_enabled()) return v;
      for (int l = 0; l < LANES; l++) begin
         if (mask[l]) v[l*XLEN +: XLEN] = ref_lane(op, s1, s2, a[l*XLEN +: XLEN], b[l*XLEN +: XLEN]);
         else         v[l*XLEN +: XLEN] = a[l*XLEN +: XLEN];
      end
      return v;
   endfunction

   function automatic logic [XLEN-1:0] div_lit(input logic [XLEN-1:0] v);
      return div_enabled() ? v : '0;
   endfunction

   // Called at posedge+1; returns at posedge+1 with the unit back in IDLE.
   task automatic run_op(input string tag, input logic [1:0] op, input logic s1, input logic s2,
                         input logic [LANES-1:0] mask, input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input int hold);
      logic [VW-1:0] exp_res;
      logic          exp_ill;
      int            guard;
      int            cyc;
      exp_res = ref_vec(op, s1, s2, mask, a, b);
      exp_ill = (op >= 2'd2) && !div_enabled();
      resp_ready      = (hold == 0);
      req_valid       = 1'b1;
      req_op          = op;
      req_in_1_signed = s1;
      req_in_2_signed = s2;
      req_mask        = mask;
      req_in_1        = a;
      req_in_2        = b;
      guard = 0;
      while (!req_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check({tag, " req_ready before accept"}, VW'(req_ready), VW'(1));
      @(posedge clk); #1;
      req_valid       = 1'b0;
      req_op          = 2'($urandom);
      req_in_1        = {$urandom, $urandom};
      req_in_2        = {$urandom, $urandom};
      req_mask        = LANES'($urandom);
      req_in_1_signed = 1'($urandom);
      cyc = 1;
      while (!resp_valid && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, " latency"}, VW'(cyc), VW'(XLEN + 2));
      check({tag, " result"}, resp_result, exp_res);
      check({tag, " illegal"}, VW'(resp_illegal), VW'(exp_ill));
      got_result = resp_result;
      if (hold > 0) begin
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, " held valid"}, VW'(resp_valid), VW'(1));
            check({tag, " held result"}, resp_result, exp_res);
            check({tag, " held req_ready"}, VW'(req_ready), VW'(0));
         end
         resp_ready = 1'b1;
      end
      @(posedge clk); #1;
      check({tag, " back to idle"}, VW'(req_ready), VW'(1));
   endtask

   function automatic logic [XLEN-1:0] rand_word();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return XLEN'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int seen;
      reset           = 1'b1;
      req_valid       = 1'b0;
      req_op          = '0;
      req_in_1_signed = 1'b0;
      req_in_2_signed = 1'b0;
      req_mask        = '0;
      req_in_1        = '0;
      req_in_2        = '0;
      resp_ready      = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset req_ready", VW'(req_ready), VW'(1));
      check("reset resp_valid", VW'(resp_valid), VW'(0));
      check("reset resp_illegal", VW'(resp_illegal), VW'(0));
      check("reset resp_result", resp_result, '0);
      reset = 1'b0;
      @(posedge clk); #1;

      run_op("smul", 2'd0, 1'b1, 1'b1, 2'b11, {32'd7, 32'd7}, {32'hFFFF_FFFD, 32'hFFFF_FFFD}, 0);
      check("smul lane0 literal", VW'(got_result[31:0]), VW'(32'hFFFF_FFEB));
      run_op("umulh", 2'd1, 1'b0, 1'b0, 2'b11, {32'hFFFF_FFFF, 32'd2}, {32'hFFFF_FFFF, 32'd3}, 0);
      check("umulh lane1 literal", VW'(got_result[63:32]), VW'(32'hFFFF_FFFE));
      run_op("sdiv", 2'd2, 1'b1, 1'b1, 2'b11, {2{32'hFFFF_FFF9}}, {2{32'd2}}, 0);
      check("sdiv literal", VW'(got_result[31:0]), VW'(div_lit(32'hFFFF_FFFD)));
      run_op("srem", 2'd3, 1'b1, 1'b1, 2'b11, {2{32'hFFFF_FFF9}}, {2{32'd2}}, 0);
      check("srem literal", VW'(got_result[31:0]), VW'(div_lit(32'hFFFF_FFFF)));
      run_op("udiv", 2'd2, 1'b0, 1'b0, 2'b11, {2{32'hFFFF_FFFE}}, {2{32'd3}}, 0);
      check("udiv literal", VW'(got_result[31:0]), VW'(div_lit(32'h5555_5554)));
      run_op("div0", 2'd2, 1'b1, 1'b1, 2'b11, {2{32'd5}}, {2{32'd0}}, 0);
      check("div0 literal", VW'(got_result[31:0]), VW'(div_lit(32'hFFFF_FFFF)));
      run_op("rem0", 2'd3, 1'b1, 1'b1, 2'b11, {2{32'hFFFF_FFFB}}, {2{32'd0}}, 0);
      check("rem0 literal", VW'(got_result[31:0]), VW'(div_lit(32'hFFFF_FFFB)));
      run_op("divovf", 2'd2, 1'b1, 1'b1, 2'b11, {2{32'h8000_0000}}, {2{32'hFFFF_FFFF}}, 0);
      check("divovf literal", VW'(got_result[31:0]), VW'(div_lit(32'h8000_0000)));
      run_op("removf", 2'd3, 1'b1, 1'b1, 2'b11, {2{32'h8000_0000}}, {2{32'hFFFF_FFFF}}, 0);
      check("removf literal", VW'(got_result[31:0]), VW'(32'd0));
      run_op("mask", 2'd0, 1'b0, 1'b0, 2'b01, {32'h1234_5678, 32'd3}, {32'd4, 32'd4}, 0);
      check("mask literal", got_result, {32'h1234_5678, 32'h0000_000C});
      run_op("hold", 2'd0, 1'b1, 1'b0, 2'b11, {32'hDEAD_BEEF, 32'h0000_1234}, {32'h0000_0100, 32'h0001_0001}, 5);

      // Reset in the middle of COMPUTE drops the operation without a response.
      req_valid = 1'b1; req_op = 2'd0; req_mask = 2'b11;
      req_in_1 = {2{32'd9}}; req_in_2 = {2{32'd9}};
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("mid busy", VW'(req_ready), VW'(0));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid reset req_ready", VW'(req_ready), VW'(1));
      check("mid reset resp_valid", VW'(resp_valid), VW'(0));
      seen = 0;
      repeat (XLEN + 5) begin
         @(posedge clk); #1;
         if (resp_valid) seen++;
      end
      check("mid reset no response", VW'(seen), VW'(0));
      run_op("post reset mul", 2'd0, 1'b0, 1'b0, 2'b11, {32'd1000, 32'd6}, {32'd1000, 32'd7}, 0);

      for (int i = 0; i < 60; i++) begin
         run_op($sformatf("rand%0d", i), 2'($urandom), 1'($urandom), 1'($urandom),
                LANES'($urandom_range(0, 3) == 0 ? $urandom : 32'hFFFF_FFFF),
                {rand_word(), rand_word()}, {rand_word(), rand_word()},
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
